// File: rtl/lab_sipo_reg.sv
// Serial-in/parallel-out receive register, MSB first, with a one-entry valid/ready output buffer.
// Optional even-parity trailer bit per word when PARITY_CHECK_EN is defined.
module lab_sipo_reg #(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ser_in,
  input  logic         ser_valid,
  input  logic         start,
  output logic [n-1:0] data_out,
  output logic         data_valid,
  input  logic         data_ready,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  localparam int unsigned CW = $clog2(n + 1);
`ifdef PARITY_CHECK_EN
  localparam int unsigned SW = n;
`else
  // The final data bit comes straight from ser_in, so only n-1 bits need storing.
  localparam int unsigned SW = n - 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef PARITY_CHECK_EN
    , S_PAR = 2'd2
`endif
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [SW-1:0]   sreg, sreg_d;
  logic [n-1:0]    data_out_d;
  logic            data_valid_d;
  logic            overrun_d;
  logic            busy_d;
  logic            parity_err_d;

  // Next-state and next-output logic; start realigns before the current bit is taken.
  always_comb begin
    state_t        st;
    logic [CW-1:0] c;
    logic [SW-1:0] s;
    logic [n-1:0]  nxt;
    logic [n-1:0]  word;
    logic          complete;
    logic          buf_free;

    st           = start ? S_IDLE : state;
    c            = start ? '0 : cnt;
    s            = start ? '0 : sreg;
`ifdef PARITY_CHECK_EN
    nxt          = {s[n-2:0], ser_in};
`else
    nxt          = {s, ser_in};
`endif
    word         = nxt;
    complete     = 1'b0;
    buf_free     = ~data_valid | data_ready;

    state_d      = st;
    cnt_d        = c;
    sreg_d       = s;
    overrun_d    = start ? 1'b0 : overrun;
    data_out_d   = data_out;
    data_valid_d = data_valid & ~data_ready;
    parity_err_d = 1'b0;

    if (ser_valid) begin
      case (st)
        S_IDLE: begin
          sreg_d  = nxt[SW-1:0];
          cnt_d   = CW'(1);
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          sreg_d = nxt[SW-1:0];
          if (c == CW'(n - 1)) begin
`ifdef PARITY_CHECK_EN
            cnt_d   = CW'(n);
            state_d = S_PAR;
`else
            cnt_d    = '0;
            state_d  = S_IDLE;
            complete = 1'b1;
`endif
          end else begin
            cnt_d = c + CW'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        S_PAR: begin
          cnt_d   = '0;
          state_d = S_IDLE;
          word    = s;
          if (^{s, ser_in}) begin
            parity_err_d = 1'b1;
          end else begin
            complete = 1'b1;
          end
        end
`endif
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end

    // A finished word either takes the buffer or is counted as an overrun.
    if (complete) begin
      if (buf_free) begin
        data_out_d   = word;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sreg       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      sreg       <= sreg_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      overrun    <= overrun_d;
      busy       <= busy_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_err_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
